// File: rtl/disp_pkg.sv
// Shared constants and types for the multiplexed six-digit clock display.
// Segment patterns are active-high {g,f,e,d,c,b,a}.
package disp_pkg;

   localparam int NUM_DIGITS = 6;

   typedef logic [2:0] idx_t;
   typedef logic [7:0] digit_t;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   // Digit positions with special treatment
   localparam idx_t IDX_LAST = idx_t'(NUM_DIGITS - 1);
   localparam idx_t IDX_DP_A = 3'd2;
   localparam idx_t IDX_DP_B = 3'd4;

endpackage

// File: rtl/seg7_decode.sv
// Binary digit value to active-high seven-segment pattern.
// Out-of-range values show a dash.
module seg7_decode
   import disp_pkg::*;
(
   input  logic [7:0] value,
   output logic [6:0] pattern
);

   always_comb begin
      pattern = SEG_DASH;
      case (value)
         8'd0:    pattern = SEG_0;
         8'd1:    pattern = SEG_1;
         8'd2:    pattern = SEG_2;
         8'd3:    pattern = SEG_3;
         8'd4:    pattern = SEG_4;
         8'd5:    pattern = SEG_5;
         8'd6:    pattern = SEG_6;
         8'd7:    pattern = SEG_7;
         8'd8:    pattern = SEG_8;
         8'd9:    pattern = SEG_9;
         default: pattern = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/disp_scan.sv
// Six-digit multiplexed display scanner with frame-coherent shadowing,
// separator dots, per-digit blink and leading-zero blanking.
module disp_scan
   import disp_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int BLINK_FRAMES = 64,
   parameter int ACTIVE_LOW   = 1,
   parameter int BLANK_LZ     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] sec_lo,
   input  logic [7:0] sec_hi,
   input  logic [7:0] min_lo,
   input  logic [7:0] min_hi,
   input  logic [7:0] hr_lo,
   input  logic [7:0] hr_hi,
   input  logic [5:0] blink_mask,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
   localparam logic [FW-1:0] FR_MAX  = FW'(BLINK_FRAMES - 1);
   localparam logic [NUM_DIGITS-1:0] AN_ONE = 1;

   logic [CW-1:0] cnt;
   logic [FW-1:0] fcnt;
   idx_t          idx;
   logic          phase;
   logic          tick;
   logic          wrap;

   digit_t raw    [NUM_DIGITS];
   digit_t shadow [NUM_DIGITS];
   digit_t cur;

   logic [6:0]            pat;
   logic                  dark;
   logic [NUM_DIGITS-1:0] an_d;
   logic [6:0]            seg_d;
   logic                  dp_d;
   logic [NUM_DIGITS-1:0] an_q;
   logic [6:0]            seg_q;
   logic                  dp_q;

   assign raw[0] = sec_lo;
   assign raw[1] = sec_hi;
   assign raw[2] = min_lo;
   assign raw[3] = min_hi;
   assign raw[4] = hr_lo;
   assign raw[5] = hr_hi;

   assign tick  = (cnt == CNT_MAX);
   assign wrap  = tick && (idx == IDX_LAST);
   assign frame = wrap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= '0;
      end else if (wrap) begin
         idx <= '0;
      end else if (tick) begin
         idx <= idx + 1'b1;
      end
   end

   // Snapshot the whole time value once per frame so a frame never tears
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow[i] <= '0;
         end
      end else if (wrap) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow[i] <= raw[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fcnt  <= '0;
         phase <= 1'b0;
      end else if (wrap) begin
         if (fcnt == FR_MAX) begin
            fcnt  <= '0;
            phase <= ~phase;
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end
   end

   assign cur = shadow[idx];

   seg7_decode u_dec (
      .value   (cur),
      .pattern (pat)
   );

   // blink_mask is used live so set-mode feedback is immediate
   always_comb begin
      an_d  = '0;
      seg_d = SEG_OFF;
      dp_d  = 1'b0;
      dark  = (phase && blink_mask[idx])
           || ((BLANK_LZ != 0) && (idx == IDX_LAST) && (cur == 8'd0));
      if (en) begin
         an_d = AN_ONE << idx;
         if (!dark) begin
            seg_d = pat;
            dp_d  = (idx == IDX_DP_A) || (idx == IDX_DP_B);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_q  <= '0;
         seg_q <= SEG_OFF;
         dp_q  <= 1'b0;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   // Pin polarity is applied after the registers, adding no latency
   assign an  = (ACTIVE_LOW != 0) ? ~an_q  : an_q;
   assign seg = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
   assign dp  = (ACTIVE_LOW != 0) ? ~dp_q  : dp_q;

endmodule

// File: tb/tb_disp_scan.sv
// Scoreboard bench for disp_scan: a cycle-arithmetic model of the scan
// predicts every output cycle, a monitor compares against the pins.
module tb_disp_scan;

   localparam int SD    = 4;
   localparam int BF    = 2;
   localparam int FRAME = 6 * SD;

   typedef struct packed {
      int          cyc;
      logic [14:0] v;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b1;
   logic [7:0] dig [6];
   logic [5:0] blink_mask = '0;
   logic [5:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame;

   int   cmps = 0;
   int   errs = 0;
   int   e    = 0;
   bit   done = 0;
   exp_t q [$];
   logic [7:0] snap [6];

   logic [6:0] pat_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   always #5 clk = ~clk;

   disp_scan #(
      .SCAN_DIV     (SD),
      .BLINK_FRAMES (BF),
      .ACTIVE_LOW   (1),
      .BLANK_LZ     (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .sec_lo     (dig[0]),
      .sec_hi     (dig[1]),
      .min_lo     (dig[2]),
      .min_hi     (dig[3]),
      .hr_lo      (dig[4]),
      .hr_hi      (dig[5]),
      .blink_mask (blink_mask),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame      (frame)
   );

   function automatic logic [6:0] pat(input logic [7:0] v);
      if (v < 8'd10) return pat_tab[v[3:0]];
      return 7'h40;
   endfunction

   // Pins (active-low) expected in the cycle after clock edge n
   function automatic logic [14:0] expect_at(input int n);
      int         d;
      int         ix;
      int         ph;
      logic [7:0] v;
      logic       dk;
      logic [5:0] one;
      logic [5:0] a;
      logic [6:0] s;
      logic       p;
      logic       fr;
      d   = n - 1;
      ix  = (d / SD) % 6;
      ph  = ((d / FRAME) / BF) % 2;
      v   = snap[ix];
      dk  = (ph == 1 && blink_mask[ix]) || (ix == 5 && v == 8'd0);
      one = 6'd1;
      a   = 6'h3F;
      s   = 7'h7F;
      p   = 1'b1;
      if (en) begin
         a = ~(one << ix);
         if (!dk) begin
            s = ~pat(v);
            p = !(ix == 2 || ix == 4);
         end
      end
      fr = ((n + 1) % FRAME) == 0;
      return {a, s, p, fr};
   endfunction

   task automatic check(input string name, input logic [14:0] got,
                        input logic [14:0] want);
      cmps++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s: got an=%b seg=%h dp=%b frame=%b want an=%b seg=%h dp=%b frame=%b",
                  name, got[14:9], got[8:2], got[1], got[0],
                  want[14:9], want[8:2], want[1], want[0]);
      end
   endtask

   task automatic mutate();
      int k;
      if ($urandom_range(0, 7) == 0) begin
         k = $urandom_range(0, 5);
         if ($urandom_range(0, 3) == 0) dig[k] = 8'($urandom_range(0, 255));
         else dig[k] = 8'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 63) == 0) en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 47) == 0) blink_mask = 6'($urandom);
   endtask

   task automatic advance(input bit rnd);
      exp_t x;
      @(posedge clk);
      e++;
      x.cyc = e;
      x.v   = expect_at(e);
      q.push_back(x);
      if (e % FRAME == 0) begin
         for (int i = 0; i < 6; i++) snap[i] = dig[i];
      end
      @(negedge clk);
      if (rnd) mutate();
   endtask

   initial begin
      for (int i = 0; i < 6; i++) begin
         dig[i]  = '0;
         snap[i] = '0;
      end
      fork
         begin : stim
            rst = 1'b1;
            repeat (3) @(negedge clk);
            check("reset", {an, seg, dp, frame}, {6'h3F, 7'h7F, 1'b1, 1'b0});
            dig[0] = 8'd9; dig[1] = 8'd5; dig[2] = 8'd9;
            dig[3] = 8'd5; dig[4] = 8'd3; dig[5] = 8'd2;
            rst = 1'b0;
            e   = 0;
            repeat (3 * FRAME) advance(0);
            dig[0] = 8'd3;
            repeat (FRAME) advance(0);
            while (((e / SD) % 6) != 2) advance(0);
            dig[0] = 8'd4;
            repeat (2 * FRAME) advance(0);
            dig[5] = 8'd0;
            dig[4] = 8'd12;
            repeat (2 * FRAME) advance(0);
            blink_mask = 6'b000011;
            repeat (5 * FRAME) advance(0);
            blink_mask = 6'b000000;
            en = 1'b0;
            repeat (2 * FRAME) advance(0);
            en = 1'b1;
            repeat (2000) advance(1);
            en = 1'b1;
            while (((e / SD) % 6) != 3) advance(0);
            #2 rst = 1'b1;
            #1 check("rst_async", {an, seg, dp, frame},
                     {6'h3F, 7'h7F, 1'b1, 1'b0});
            @(posedge clk);
            @(negedge clk);
            check("rst_hold", {an, seg, dp, frame},
                  {6'h3F, 7'h7F, 1'b1, 1'b0});
            rst = 1'b0;
            e   = 0;
            for (int i = 0; i < 6; i++) snap[i] = '0;
            repeat (2 * FRAME) advance(0);
            repeat (500) advance(1);
            @(negedge clk);
            done = 1;
         end
         begin : mon
            exp_t        x;
            logic [14:0] got;
            while (!done) begin
               @(negedge clk);
               if (q.size() > 0) begin
                  x   = q.pop_front();
                  got = {an, seg, dp, frame};
                  cmps++;
                  if (got !== x.v) begin
                     errs++;
                     if (errs <= 20)
                        $display("FAIL scan edge=%0d: got an=%b seg=%h dp=%b frame=%b want an=%b seg=%h dp=%b frame=%b",
                                 x.cyc, got[14:9], got[8:2], got[1], got[0],
                                 x.v[14:9], x.v[8:2], x.v[1], x.v[0]);
                  end
               end
            end
         end
      join
      cmps++;
      if (q.size() != 0) begin
         errs++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 1000: clk cycles each digit is shown (minimum 2).
REQ-002 SHALL provide parameter BLINK_FRAMES, default 64: full scan frames per blink half-period.
REQ-003 SHALL provide parameter ACTIVE_LOW, default 1: 1 inverts an, seg and dp at the pins.
REQ-004 SHALL provide parameter BLANK_LZ, default 1: 1 blanks a leading zero in the hours-tens digit.
REQ-005 clk  in  1  system clock; rising edge active.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 en  in  1  display enable; 0 forces all digits dark.
REQ-008 sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi  in  8 each  binary digit values from the counter chain.
REQ-009 blink_mask  in  6  per-digit blink enable; bit i matches digit index i.
REQ-010 an  out  6  one-hot digit select.
REQ-011 seg  out  7  segments {g,f,e,d,c,b,a}.
REQ-012 dp  out  1  decimal point, used as the separator.
REQ-013 frame  out  1  one-cycle pulse at each full-scan wrap.

Function
REQ-014 Prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; tick SHALL assert in the cycle where count = SCAN_DIV-1.
REQ-015 Digit index idx SHALL advance on tick through 0..5 and wrap from 5 to 0. Digit map: 0 sec_lo, 1 sec_hi, 2 min_lo, 3 min_hi, 4 hr_lo, 5 hr_hi.
REQ-016 On a tick with idx=5, all six inputs SHALL latch into shadow registers, so the display never tears mid-frame. frame SHALL pulse high for exactly that cycle.
REQ-017 Display decode SHALL use shadow values only; the raw inputs SHALL never drive seg directly.
REQ-018 Decode (active-high logic): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any value 10..255 SHALL decode to dash=40.
REQ-019 dp SHALL be lit on idx 2 and idx 4 and dark on all other digits.
REQ-020 Blink phase SHALL toggle after every BLINK_FRAMES frame pulses. When phase=1 and blink_mask[idx]=1, seg and dp SHALL be dark while an stays active.
REQ-021 With BLANK_LZ=1, idx 5 with shadow hr_hi=0 SHALL show seg and dp dark.
REQ-022 With en=0, an SHALL be all inactive and seg and dp dark. Prescaler, idx, shadows and blink SHALL keep running.
REQ-023 an, seg and dp SHALL be registered and SHALL reflect the new idx exactly 1 cycle after the tick edge.
REQ-024 ACTIVE_LOW inversion SHALL be applied after registration, as a final stage with no added latency.
REQ-025 blink_mask SHALL be sampled live, not shadowed, so that set-mode response is immediate.

Reset
REQ-026 rst SHALL asynchronously clear the prescaler, idx, shadows, blink phase, frame counter and frame.
REQ-027 During reset, an SHALL be inactive and seg and dp dark, in the polarity set by ACTIVE_LOW.
REQ-028 After reset release, the first tick SHALL occur SCAN_DIV cycles later. The first shadow load SHALL occur at the first 5->0 wrap; all-zero shadows shall be shown until then.
REQ-029 Reset asserted mid-frame SHALL abort the scan with no residual digit select.

Structure
REQ-030 Shared package disp_pkg SHALL hold the ten digit pattern constants, SEG_DASH, SEG_OFF and NUM_DIGITS=6.
REQ-031 A combinational sub-module seg7_decode (8-bit value -> 7-bit pattern) SHALL be used; disp_scan SHALL hold all sequential logic.

Verification
REQ-032 SCAN_DIV=4, en=1, inputs sec_lo..hr_hi = 9,5,9,5,3,2 -> an walks 000001..100000, each held 4 cycles. seg sequence 6F, 6D, 6F, 6D, 4F, 5B. dp high on idx 2 and 4.
REQ-033 Change sec_lo from 3 to 4 while idx=2 -> seg shows 4F for sec_lo until the next 5->0 wrap, then 66.
REQ-034 hr_hi=0 with BLANK_LZ=1 -> idx 5 shows seg 00 with an bit 5 active. Same test with hr_lo=12 -> idx 4 shows 40.
REQ-035 BLINK_FRAMES=2, blink_mask=000011 -> after 2 frame pulses, digits 0-1 show seg 00 and digits 2-5 are unchanged. After 2 more frame pulses, digits 0-1 are restored.
REQ-036 Assert rst for 1 cycle at idx=3 -> an, seg, dp and frame immediately go inactive. After release, idx restarts at 0 and the first tick follows 4 cycles later.
REQ-037 ACTIVE_LOW=1 with en=0 -> an=111111 and seg=7F. frame continues to pulse every 24 cycles.
